mem_access_stage: RTL

Memory-access stage sitting directly downstream of the EX/MEM pipeline register. Consumes the registered ALU result, store data and control bits, and performs loads/stores over a variable-latency req/ack data-memory port. Back-pressures upstream with `stall`. Produces the registered MEM/WB bundle for write-back.

---
 rtl/mem_access_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: loads/stores over a req/ack data port with timeout abort.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  in_pc,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_write_data,
  input  logic [2:0]  in_jump_type,
  input  logic        in_reg_wrenable,
  input  logic [4:0]  in_write_reg,
  input  logic        in_mem_wrenable,
  input  logic        in_mem_to_reg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_pc,
  output logic [2:0]  wb_jump_type,
  output logic        wb_reg_wrenable,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state, state_d;

  logic [CW-1:0] cnt;
  logic [4:0]    l_pc;
  logic [31:0]   l_alu;
  logic [2:0]    l_jt;
  logic          l_rwe;
  logic [4:0]    l_wr;
  logic          l_store;

  logic mem_op, bad_align, last;
  logic accept, pass, misal, done, abort;

  assign mem_op = in_mem_wrenable | in_mem_to_reg;
  assign last   = (cnt == CW'(TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_align = |in_alu_res[1:0];
`else
  assign bad_align = 1'b0;
`endif

  assign stall = (state == ACCESS) && !dmem_ack && !last;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    pass    = 1'b0;
    misal   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          !in_valid: ;
          in_valid && !mem_op: pass = 1'b1;
          in_valid && mem_op && bad_align: misal = 1'b1;
          in_valid && mem_op && !bad_align: begin
            accept  = 1'b1;
            state_d = ACCESS;
          end
        endcase
      end
      ACCESS: begin
        if (dmem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (last) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      l_pc            <= '0;
      l_alu           <= '0;
      l_jt            <= '0;
      l_rwe           <= 1'b0;
      l_wr            <= '0;
      l_store         <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      wb_valid        <= 1'b0;
      wb_pc           <= '0;
      wb_jump_type    <= '0;
      wb_reg_wrenable <= 1'b0;
      wb_write_reg    <= '0;
      wb_data         <= '0;
      bus_err         <= 1'b0;
      misalign        <= 1'b0;
    end else begin
      bus_err  <= abort;
      misalign <= misal;
      wb_valid <= pass | misal | done | abort;

      if (accept) begin
        cnt        <= '0;
        l_pc       <= in_pc;
        l_alu      <= in_alu_res;
        l_jt       <= in_jump_type;
        l_rwe      <= in_reg_wrenable;
        l_wr       <= in_write_reg;
        l_store    <= in_mem_wrenable;
        dmem_req   <= 1'b1;
        dmem_we    <= in_mem_wrenable;
        dmem_addr  <= {in_alu_res[31:2], 2'b00};
        dmem_wdata <= in_write_data;
      end else if (state == ACCESS && !done && !abort) begin
        cnt <= cnt + 1'b1;
      end

      // Abort keeps the bundle flowing but suppresses the register write
      if (done || abort) begin
        dmem_req        <= 1'b0;
        wb_pc           <= l_pc;
        wb_jump_type    <= l_jt;
        wb_reg_wrenable <= l_rwe & done;
        wb_write_reg    <= l_wr;
        wb_data         <= (done && !l_store) ? dmem_rdata : l_alu;
      end

      if (pass || misal) begin
        wb_pc           <= in_pc;
        wb_jump_type    <= in_jump_type;
        wb_reg_wrenable <= in_reg_wrenable & pass;
        wb_write_reg    <= in_write_reg;
        wb_data         <= in_alu_res;
      end
    end
  end

endmodule
